// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit (mdu_iter):
// op encodings, FSM state encoding, iteration count and small helpers.
package mdu_pkg;

  localparam int         MDU_ITER     = 32;
  localparam logic [5:0] MDU_CNT_LAST = 6'(MDU_ITER - 1);

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_CALC = 2'b10,
    ST_FIX  = 2'b11
  } mdu_state_e;

  // MULT and DIV are the signed flavours (op[0] clear).
  function automatic logic mdu_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // DIV and DIVU share op[1] set.
  function automatic logic mdu_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Magnitude of a 32-bit operand; only negates when the op is signed.
  function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'h0000_0000 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Trial subtraction; a clear top bit of the difference means it fits.
  always_comb begin
    shifted_s = {rem_in, dividend_bit};
    diff_s    = shifted_s - {1'b0, divisor};
    q_bit     = ~diff_s[WIDTH];
    if (q_bit) begin
      rem_out = diff_s[WIDTH-1:0];
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO.
// IDLE -> PREP (1) -> CALC (32) -> FIX (1): results land 34 edges after start.
// Optional macro MDU_FAST_MUL_EN: MULT/MULTU form the product in PREP with a
// single multiplier and skip CALC (2-edge latency); divide is unchanged.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int              WIDTH  = 32,
  parameter logic [WIDTH-1:0] DIV0_Q = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e state_r;
  mdu_state_e state_nxt_s;

  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   mag_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               div0_r;
  logic [5:0]         cnt_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;

  logic               accept_s;
  logic               sgn_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_acc_nxt_s;
  logic [WIDTH-1:0]   div_rem_nxt_s;
  logic               div_q_bit_s;
  logic [2*WIDTH-1:0] div_acc_nxt_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Divide iteration: remainder in acc[63:32], dividend/quotient in acc[31:0].
  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (acc_r[2*WIDTH-1:WIDTH]),
    .dividend_bit (acc_r[WIDTH-1]),
    .divisor      (mag_r),
    .rem_out      (div_rem_nxt_s),
    .q_bit        (div_q_bit_s)
  );

  // Next-state logic; cancel outranks start and aborts any active state.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cancel) begin
          state_nxt_s = ST_IDLE;
        end else if (start) begin
          state_nxt_s = ST_PREP;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PREP: begin
        if (cancel) begin
          state_nxt_s = ST_IDLE;
`ifdef MDU_FAST_MUL_EN
        end else if (!mdu_is_div(op_r)) begin
          state_nxt_s = ST_FIX;
`endif
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cancel) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == MDU_CNT_LAST) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_FIX: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Operand magnitudes and the per-cycle shift-add / shift-subtract results.
  always_comb begin
    sgn_s         = mdu_is_signed(op_r);
    abs_a_s       = mdu_abs(a_r, sgn_s);
    abs_b_s       = mdu_abs(b_r, sgn_s);
    mul_sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc_r[0] ? mag_r : {WIDTH{1'b0}})};
    mul_acc_nxt_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_acc_nxt_s = {div_rem_nxt_s, acc_r[WIDTH-2:0], div_q_bit_s};
  end

  // Sign correction and divide-by-zero override for the FIX write.
  always_comb begin
    prod_fix_s = neg_q_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
    fix_hi_s   = prod_fix_s[2*WIDTH-1:WIDTH];
    fix_lo_s   = prod_fix_s[WIDTH-1:0];
    if (!mdu_is_div(op_r)) begin
      fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_fix_s[WIDTH-1:0];
    end else if (div0_r) begin
      fix_hi_s = a_r;
      fix_lo_s = DIV0_Q;
    end else begin
      fix_lo_s = neg_q_r ? ({WIDTH{1'b0}} - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
      fix_hi_s = neg_r_r ? ({WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH])
                         : acc_r[2*WIDTH-1:WIDTH];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath, HI/LO and handshake registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_r    <= 2'b00;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      mag_r   <= {WIDTH{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      div0_r  <= 1'b0;
      cnt_r   <= 6'd0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // MTHI/MTLO land now; a result accepted this edge overwrites later.
          if (hi_we) hi_r <= wdata;
          if (lo_we) lo_r <= wdata;
          if (accept_s) begin
            op_r <= op;
            a_r  <= src_a;
            b_r  <= src_b;
          end
        end
        ST_PREP: begin
          if (!cancel) begin
            cnt_r   <= 6'd0;
            neg_q_r <= sgn_s & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
            if (mdu_is_div(op_r)) begin
              mag_r   <= abs_b_s;
              acc_r   <= {{WIDTH{1'b0}}, abs_a_s};
              neg_r_r <= sgn_s & a_r[WIDTH-1];
              div0_r  <= (b_r == {WIDTH{1'b0}});
            end else begin
              mag_r   <= abs_a_s;
`ifdef MDU_FAST_MUL_EN
              acc_r   <= {{WIDTH{1'b0}}, abs_a_s} * {{WIDTH{1'b0}}, abs_b_s};
`else
              acc_r   <= {{WIDTH{1'b0}}, abs_b_s};
`endif
              neg_r_r <= 1'b0;
              div0_r  <= 1'b0;
            end
          end
        end
        ST_CALC: begin
          if (!cancel) begin
            cnt_r <= cnt_r + 6'd1;
            acc_r <= mdu_is_div(op_r) ? div_acc_nxt_s : mul_acc_nxt_s;
          end
        end
        ST_FIX: begin
          if (!cancel) begin
            hi_r   <= fix_hi_s;
            lo_r   <= fix_lo_s;
            done_r <= 1'b1;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (default or MDU_FAST_MUL_EN build).
module tb_mdu_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;
  int lat;
  int mul_lat;

  mdu_iter dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .cancel (cancel),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the start edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  // Counts edges until done is seen, bounded at 100.
  task automatic wait_done(output int l);
    l = 0;
    while (done !== 1'b1 && l < 100) begin
      @(posedge clk); @(negedge clk);
      l++;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
`ifdef MDU_FAST_MUL_EN
    mul_lat = 2;
`else
    mul_lat = 34;
`endif
    reset = 1'b0; start = 1'b0; op = 2'b00; src_a = 32'h0; src_b = 32'h0;
    cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0;
    step(2);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset = 1'b1;
    step(1);

    // MULT -2 * 3
    launch(2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_busy", {31'h0, busy}, 32'h1);
    wait_done(lat);
    check("mult_lat", 32'(lat), 32'(mul_lat));
    check("mult_busy_at_done", {31'h0, busy}, 32'h0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU launched in the done cycle: must be accepted
    launch(2'b01, 32'hFFFF_FFFE, 32'h0000_0003);
    check("done_pulse_end", {31'h0, done}, 32'h0);
    check("multu_busy", {31'h0, busy}, 32'h1);
    wait_done(lat);
    check("multu_lat", 32'(lat), 32'(mul_lat));
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);
    step(1);

    // DIV -7 / 2
    launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(lat);
    check("div_lat", 32'(lat), 32'd34);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    step(1);

    // DIV 7 / -2
    launch(2'b10, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done(lat);
    check("div_nb_lo", lo, 32'hFFFF_FFFD);
    check("div_nb_hi", hi, 32'h0000_0001);
    step(1);

    // DIV most-negative / -1
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);
    step(1);

    // DIVU 7 / 0
    launch(2'b11, 32'h0000_0007, 32'h0000_0000);
    wait_done(lat);
    check("div0_lat", 32'(lat), 32'd34);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h0000_0007);
    step(1);

    // MTHI / MTLO preload
    hi_we = 1'b1; wdata = 32'h11;
    step(1);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
    step(1);
    lo_we = 1'b0;
    check("mthi", hi, 32'h11);
    check("mtlo", lo, 32'h22);

    // DIVU 100/7 cancelled at cycle 10, restart in the next cycle
    launch(2'b11, 32'd100, 32'd7);
    step(9);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    check("cancel_busy", {31'h0, busy}, 32'h0);
    check("cancel_done", {31'h0, done}, 32'h0);
    check("cancel_hi", hi, 32'h11);
    check("cancel_lo", lo, 32'h22);
    launch(2'b11, 32'd100, 32'd7);
    check("restart_busy", {31'h0, busy}, 32'h1);
    // start while busy must be ignored
    op = 2'b01; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
    step(5);
    start = 1'b0;
    wait_done(lat);
    check("restart_lat", 32'(lat), 32'd29);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    step(1);
    check("no_ghost_op", {31'h0, busy}, 32'h0);

    // cancel with start in IDLE drops the start
    cancel = 1'b1;
    launch(2'b01, 32'd9, 32'd9);
    cancel = 1'b0;
    check("idle_cancel_drop", {31'h0, busy}, 32'h0);

    // MTHI in the start cycle lands, MTLO while busy is ignored
    hi_we = 1'b1; wdata = 32'hAB;
    launch(2'b01, 32'd2, 32'd3);
    hi_we = 1'b0;
    check("mthi_with_start", hi, 32'hAB);
    lo_we = 1'b1; wdata = 32'h55;
    step(1);
    lo_we = 1'b0;
    check("mtlo_busy_ignored", lo, 32'd14);
    wait_done(lat);
    check("ovr_hi", hi, 32'h0);
    check("ovr_lo", lo, 32'd6);
    step(1);

    // MULT 6*7
    launch(2'b00, 32'd6, 32'd7);
    wait_done(lat);
    check("mul67_lat", 32'(lat), 32'(mul_lat));
    check("mul67_lo", lo, 32'd42);
    check("mul67_hi", hi, 32'd0);
    step(1);

    // reset mid-operation
    launch(2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
    step(19);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    step(40);
    check("midrst_no_result", lo, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
